sr_latch_driver: RTL
====================

Name: sr_latch_driver

Overview:
- Clocked initiator that drives the s/r inputs of a cross-coupled NOR SR latch.
- Converts single-cycle set/clear requests into clean, width-controlled s or r pulses.
- Never produces the forbidden s=r=1 combination.
- Confirms the latch changed state via q/q_bar feedback and reports done or error.
- Sits between control logic and any NOR-based storage latch in the design.

Parameters:
- PULSE_W, 2: cycles s or r is held high per operation; legal range 1..15.
- GAP, 1: dead cycles after an operation before a new request is accepted; legal range 0..15.
- TIMEOUT, 8: cycles allowed in CHECK for feedback to match before error; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- set_req  input  1  request to set the latch (q=1); sampled only in IDLE.
- clr_req  input  1  request to clear the latch (q=0); sampled only in IDLE.
- q_fb  input  1  latch q output, already synchronised to clk.
- q_bar_fb  input  1  latch q_bar output, already synchronised to clk.
- s  output  1  latch set drive, registered.
- r  output  1  latch reset drive, registered.
- busy  output  1  high while an operation or gap is in progress.
- done  output  1  one-cycle pulse: latch confirmed in target state.
- err  output  1  one-cycle pulse: conflicting request or feedback timeout.

Behaviour:
- Clock and reset:
  - Single clock, clk. rst_n is synchronous, active-low.
  - While rst_n=0 at a rising edge: s=0, r=0, busy=0, done=0, err=0, state=IDLE, all counters=0.
  - Reset mid-pulse: s and r drop at that edge. No done or err is produced.
- States: IDLE, PULSE_S, PULSE_R, CHECK, GAP. All outputs are registered.
- IDLE:
  - set_req=1, clr_req=0 at edge T0: go to PULSE_S; s=1 and busy=1 from T0+1; target=1.
  - clr_req=1, set_req=0: go to PULSE_R; r=1 and busy=1 from T0+1; target=0.
  - Both high: no pulse; err=1 for one cycle at T0+1; stay IDLE; busy stays 0.
  - Requests are accepted regardless of current q_fb; the pulse is always issued.
- PULSE_S / PULSE_R:
  - s (or r) stays high for exactly PULSE_W cycles, counted by pulse_cnt, then goes to CHECK.
  - s/r return to 0 on the same edge as the transition into CHECK.
- CHECK:
  - Each edge compares q_fb==target and q_bar_fb==~target.
  - Match: done=1 for the following cycle, then go to GAP.
  - No match: timeout counter increments. When TIMEOUT consecutive CHECK cycles have elapsed without a match, err=1 for one cycle and go to GAP.
  - q_fb==q_bar_fb (latch in the invalid state) counts as no match.
- GAP:
  - Hold GAP cycles with s=r=0, then IDLE.
  - GAP=0: go from CHECK directly to IDLE.
  - busy falls on the edge that enters IDLE.
- Request handling:
  - set_req/clr_req are ignored whenever state≠IDLE. There is no queueing.
  - A request held high across the return to IDLE is accepted on the first IDLE edge.
- Invariants:
  - s&r is never 1.
  - done and err are never high in the same cycle.
  - At most one done or err per accepted request.
- Counters:
  - pulse_cnt: 4 bits, saturates at 15.
  - Timeout counter: 8 bits.
  - Both clear on every state entry.

Test Plan:
- Defaults; bench NOR latch model with 1-cycle feedback delay. set_req pulse at cycle 0 -> s=1 cycles 1–2; r=0 throughout; done=1 once in cycle 4 or 5; busy low after GAP; q_fb=1.
- From q=1, clr_req for one cycle -> r=1 for 2 cycles, s=0 throughout; done once; q_fb=0, q_bar_fb=1.
- set_req=clr_req=1 in IDLE -> s=r=0; err=1 exactly one cycle; busy stays 0; next clean set_req is accepted normally.
- Feedback tied stuck at q_fb=0, q_bar_fb=1; issue set_req -> s pulses 2 cycles, then 8 CHECK cycles; err=1 once; done never; returns to IDLE.
- set_req held high continuously with PULSE_W=3, GAP=2 -> repeated s pulses of exactly 3 cycles, separated by CHECK+2 gap cycles; s&r=0 every cycle.
- rst_n=0 asserted during cycle 2 of an r pulse -> r=0, busy=0 after that edge; no done/err; first request after reset release is accepted.

Source files
------------

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - clocked s/r pulse driver for a cross-coupled NOR SR latch
// Issues width-controlled set/reset pulses and confirms the latch through q/q_bar feedback.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    input  logic q_bar_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE,
        PULSE_S,
        PULSE_R,
        CHECK,
        GAP_WAIT
    } state_t;

    localparam logic [3:0] PW_LAST  = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] pulse_cnt;
    logic [7:0] tmo_cnt;
    logic       target;
    logic       match;

    // An invalid latch (q_fb == q_bar_fb) can never satisfy both terms.
    assign match = (q_fb == target) && (q_bar_fb == ~target);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pulse_cnt <= 4'd0;
            tmo_cnt   <= 8'd0;
            target    <= 1'b0;
            s         <= 1'b0;
            r         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (set_req && clr_req) begin
                        err <= 1'b1;
                    end else if (set_req) begin
                        state     <= PULSE_S;
                        s         <= 1'b1;
                        busy      <= 1'b1;
                        target    <= 1'b1;
                        pulse_cnt <= 4'd0;
                    end else if (clr_req) begin
                        state     <= PULSE_R;
                        r         <= 1'b1;
                        busy      <= 1'b1;
                        target    <= 1'b0;
                        pulse_cnt <= 4'd0;
                    end
                end
                PULSE_S, PULSE_R: begin
                    if (pulse_cnt == PW_LAST) begin
                        state     <= CHECK;
                        s         <= 1'b0;
                        r         <= 1'b0;
                        pulse_cnt <= 4'd0;
                        tmo_cnt   <= 8'd0;
                    end else begin
                        pulse_cnt <= sat_inc(pulse_cnt);
                    end
                end
                CHECK: begin
                    if (match || (tmo_cnt == TO_LAST)) begin
                        done      <= match;
                        err       <= ~match;
                        pulse_cnt <= 4'd0;
                        tmo_cnt   <= 8'd0;
                        if (GAP == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP_WAIT;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                GAP_WAIT: begin
                    if (pulse_cnt == GAP_LAST) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        pulse_cnt <= 4'd0;
                    end else begin
                        pulse_cnt <= sat_inc(pulse_cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
